// File: rtl/wb_commit_queue_pkg.sv
// Shared types for the multi-lane writeback commit queue: buffered entries,
// per-port retire bundles and the exception codes the trace logic needs.
package wb_commit_queue_pkg;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
    logic        eret;
  } wb_entry_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } wb_retire_t;

  function automatic logic is_addr_exc(input wb_entry_t e);
    return e.ex && ((e.exccode == EXCCODE_ADEL) || (e.exccode == EXCCODE_ADES));
  endfunction

  // Address faults report the faulting address on the write-data trace lane.
  function automatic wb_retire_t make_retire(input wb_entry_t e, input logic en, input logic kill);
    wb_retire_t r;
    r = '0;
    if (en) begin
      r.we    = kill ? 4'h0 : e.rf_we;
      r.waddr = e.dest;
      r.wdata = is_addr_exc(e) ? e.badvaddr : e.result;
      r.pc    = e.pc;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_retire_select.sv
// Scans the oldest RETIRE buffered entries and decides how many retire this
// cycle, stopping at the first exception/ERET (which retires alone at the head).
module wb_retire_select
  import wb_commit_queue_pkg::*;
#(
  parameter int RETIRE = 2,
  parameter int RCNT_W = $clog2(RETIRE + 1)
) (
  input  logic [RETIRE-1:0]            win_valid,
  input  wb_entry_t [RETIRE-1:0]       win_entry,
  output logic [RCNT_W-1:0]            retire_cnt,
  output logic [RETIRE-1:0]            port_en,
  output logic                         flush_sel
);

  logic stop;

  always_comb begin
    retire_cnt = '0;
    port_en    = '0;
    flush_sel  = 1'b0;
    stop       = 1'b0;
    for (int i = 0; i < RETIRE; i++) begin
      if (!stop) begin
        if (!win_valid[i]) begin
          stop = 1'b1;
        end else if (win_entry[i].ex || win_entry[i].eret) begin
          // Younger faulting entries wait until they reach the head.
          stop = 1'b1;
          if (i == 0) begin
            flush_sel  = 1'b1;
            port_en[0] = 1'b1;
            retire_cnt = RCNT_W'(1);
          end
        end else begin
          port_en[i] = 1'b1;
          retire_cnt = retire_cnt + RCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Multi-lane in-order commit buffer between MEM and the register file; retires
// up to RETIRE entries per cycle and raises a precise flush at the head.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int RETIRE = 2,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [LANES-1:0]          in_valid,
  input  wb_entry_t [LANES-1:0]     in_entry,
  output logic                      in_ready,
  output logic [RETIRE-1:0][3:0]    rf_we,
  output logic [RETIRE-1:0][4:0]    rf_waddr,
  output logic [RETIRE-1:0][31:0]   rf_wdata,
  output logic                      flush,
  output logic                      flush_is_eret,
  output logic [31:0]               flush_pc,
  output logic [4:0]                flush_exccode,
  output logic [31:0]               flush_badvaddr,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [RETIRE-1:0][31:0]   debug_wb_pc,
  output logic [RETIRE-1:0][3:0]    debug_wb_rf_wen,
  output logic [RETIRE-1:0][4:0]    debug_wb_rf_wnum,
  output logic [RETIRE-1:0][31:0]   debug_wb_rf_wdata
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PCNT_W = $clog2(LANES + 1);
  localparam int RCNT_W = $clog2(RETIRE + 1);

  wb_entry_t entry_mem [DEPTH];

  logic [PTR_W-1:0]        head_reg, head_next;
  logic [PTR_W-1:0]        tail_reg, tail_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [PCNT_W-1:0]       push_cnt;
  logic                    push_en;
  logic [RETIRE-1:0]       win_valid;
  wb_entry_t [RETIRE-1:0]  win_entry;
  logic [RCNT_W-1:0]       retire_cnt;
  logic [RETIRE-1:0]       port_en;
  logic                    flush_sel;
  wb_retire_t [RETIRE-1:0] port;

  assign in_ready = (count_reg <= CNT_W'(DEPTH - LANES));

  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      push_cnt = push_cnt + PCNT_W'(in_valid[i]);
    end
  end

  // A flushing cycle squashes whatever MEM presents alongside it.
  assign push_en = in_ready && (|in_valid) && !flush_sel;

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) begin
          entry_mem[tail_reg + PTR_W'(i)] <= in_entry[i];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RETIRE; gi++) begin : g_win
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx         = head_reg + PTR_W'(gi);
      assign win_entry[gi]  = entry_mem[rd_idx];
      assign win_valid[gi]  = (count_reg > CNT_W'(gi));
    end
  endgenerate

  wb_retire_select #(
    .RETIRE (RETIRE),
    .RCNT_W (RCNT_W)
  ) u_retire_select (
    .win_valid  (win_valid),
    .win_entry  (win_entry),
    .retire_cnt (retire_cnt),
    .port_en    (port_en),
    .flush_sel  (flush_sel)
  );

  always_comb begin
    head_next  = head_reg + PTR_W'(retire_cnt);
    tail_next  = push_en ? (tail_reg + PTR_W'(push_cnt)) : tail_reg;
    count_next = count_reg + (push_en ? CNT_W'(push_cnt) : '0) - CNT_W'(retire_cnt);
    if (flush_sel) begin
      head_next  = tail_reg;
      tail_next  = tail_reg;
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  generate
    for (gi = 0; gi < RETIRE; gi++) begin : g_port
      assign port[gi]              = make_retire(win_entry[gi], port_en[gi], flush_sel);
      assign rf_we[gi]             = port[gi].we;
      assign rf_waddr[gi]          = port[gi].waddr;
      assign rf_wdata[gi]          = port[gi].wdata;
      assign debug_wb_pc[gi]       = port[gi].pc;
      assign debug_wb_rf_wen[gi]   = port[gi].we;
      assign debug_wb_rf_wnum[gi]  = port[gi].waddr;
      assign debug_wb_rf_wdata[gi] = port[gi].wdata;
    end
  endgenerate

  assign flush          = flush_sel;
  assign flush_is_eret  = flush_sel && win_entry[0].eret;
  assign flush_pc       = flush_sel ? win_entry[0].pc       : '0;
  assign flush_exccode  = flush_sel ? win_entry[0].exccode  : '0;
  assign flush_badvaddr = flush_sel ? win_entry[0].badvaddr : '0;
  assign occupancy      = count_reg;

  a_in_valid_prefix: assert property (
    @(posedge clk) disable iff (!resetn)
      (in_valid & (in_valid + LANES'(1))) == '0
  );

endmodule

// File: tb/tb_wb_commit_queue.sv
// Drives a 2-retire and a 1-retire commit queue with the same MEM stream and
// compares both against queue-based reference models.
module tb_wb_commit_queue;
  import wb_commit_queue_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [LANES-1:0] in_valid;
  wb_entry_t [LANES-1:0] in_entry;

  logic rdy_a, fl_a, fle_a;
  logic [1:0][3:0] we_a, dwe_a;
  logic [1:0][4:0] wa_a, dwn_a;
  logic [1:0][31:0] wd_a, dwd_a, dpc_a;
  logic [31:0] fpc_a, fbv_a;
  logic [4:0] fec_a;
  logic [3:0] occ_a;

  logic rdy_b, fl_b, fle_b;
  logic [0:0][3:0] we_b, dwe_b;
  logic [0:0][4:0] wa_b, dwn_b;
  logic [0:0][31:0] wd_b, dwd_b, dpc_b;
  logic [31:0] fpc_b, fbv_b;
  logic [4:0] fec_b;
  logic [3:0] occ_b;

  always #5 clk = ~clk;

  wb_commit_queue #(.LANES(LANES), .RETIRE(2), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_entry(in_entry), .in_ready(rdy_a),
    .rf_we(we_a), .rf_waddr(wa_a), .rf_wdata(wd_a),
    .flush(fl_a), .flush_is_eret(fle_a), .flush_pc(fpc_a), .flush_exccode(fec_a),
    .flush_badvaddr(fbv_a), .occupancy(occ_a),
    .debug_wb_pc(dpc_a), .debug_wb_rf_wen(dwe_a), .debug_wb_rf_wnum(dwn_a), .debug_wb_rf_wdata(dwd_a)
  );

  wb_commit_queue #(.LANES(LANES), .RETIRE(1), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_entry(in_entry), .in_ready(rdy_b),
    .rf_we(we_b), .rf_waddr(wa_b), .rf_wdata(wd_b),
    .flush(fl_b), .flush_is_eret(fle_b), .flush_pc(fpc_b), .flush_exccode(fec_b),
    .flush_badvaddr(fbv_b), .occupancy(occ_b),
    .debug_wb_pc(dpc_b), .debug_wb_rf_wen(dwe_b), .debug_wb_rf_wnum(dwn_b), .debug_wb_rf_wdata(dwd_b)
  );

  int tests = 0;
  int fails = 0;

  wb_entry_t qa[$];
  wb_entry_t qb[$];
  int   n_exp [2];
  logic fl_exp [2];
  logic rdy_exp [2];
  logic track_order = 1'b0;
  logic [31:0] last_pc_b = '0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_entry_t mk_ok(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    wb_entry_t e;
    e = '0;
    e.pc = pc; e.dest = d; e.rf_we = 4'hF; e.result = r;
    return e;
  endfunction

  function automatic wb_entry_t mk_ex(input logic [31:0] pc, input logic [4:0] ec, input logic [31:0] bv);
    wb_entry_t e;
    e = mk_ok(pc, 5'd7, ~bv);
    e.ex = 1'b1; e.exccode = ec; e.badvaddr = bv;
    return e;
  endfunction

  function automatic wb_entry_t mk_eret(input logic [31:0] pc);
    wb_entry_t e;
    e = mk_ok(pc, 5'd9, 32'hEEEE_0000);
    e.eret = 1'b1;
    return e;
  endfunction

  function automatic wb_entry_t rnd_entry(input logic [31:0] pc);
    wb_entry_t e;
    int c;
    c = $urandom_range(0, 15);
    e = mk_ok(pc, 5'($urandom), $urandom);
    e.rf_we = 4'($urandom);
    e.badvaddr = $urandom;
    if (c == 0) e = mk_ex(pc, EXCCODE_ADEL, $urandom);
    else if (c == 1) e = mk_ex(pc, EXCCODE_ADES, $urandom);
    else if (c == 2) e = mk_ex(pc, EXCCODE_SYS, $urandom);
    else if (c == 3) e = mk_ex(pc, EXCCODE_INT, $urandom);
    else if (c == 4) e = mk_eret(pc);
    return e;
  endfunction

  // Reference: retire the oldest non-faulting run (up to ret); a fault at the head retires alone.
  task automatic check_inst(input int k);
    wb_entry_t q[$];
    int ret, n;
    logic fl;
    string nm;
    logic [1:0][3:0] o_we, o_dwe;
    logic [1:0][4:0] o_wa, o_dwn;
    logic [1:0][31:0] o_wd, o_dwd, o_dpc;
    logic o_fl, o_fle, o_rdy;
    logic [31:0] o_fpc, o_fbv;
    logic [4:0] o_fec;
    logic [3:0] o_occ;
    logic [3:0] e_we;
    logic [4:0] e_wa;
    logic [31:0] e_wd, e_pc;
    o_we = '0; o_dwe = '0; o_wa = '0; o_dwn = '0; o_wd = '0; o_dwd = '0; o_dpc = '0;
    if (k == 0) begin
      q = qa; ret = 2; nm = "A";
      o_we = we_a; o_dwe = dwe_a; o_wa = wa_a; o_dwn = dwn_a;
      o_wd = wd_a; o_dwd = dwd_a; o_dpc = dpc_a;
      o_fl = fl_a; o_fle = fle_a; o_fpc = fpc_a; o_fbv = fbv_a; o_fec = fec_a;
      o_occ = occ_a; o_rdy = rdy_a;
    end else begin
      q = qb; ret = 1; nm = "B";
      o_we[0] = we_b[0]; o_dwe[0] = dwe_b[0]; o_wa[0] = wa_b[0]; o_dwn[0] = dwn_b[0];
      o_wd[0] = wd_b[0]; o_dwd[0] = dwd_b[0]; o_dpc[0] = dpc_b[0];
      o_fl = fl_b; o_fle = fle_b; o_fpc = fpc_b; o_fbv = fbv_b; o_fec = fec_b;
      o_occ = occ_b; o_rdy = rdy_b;
    end
    n = 0;
    fl = 1'b0;
    for (int i = 0; i < ret && i < q.size(); i++) begin
      if (q[i].ex || q[i].eret) begin
        if (i == 0) begin
          fl = 1'b1;
          n = 1;
        end
        break;
      end
      n++;
    end
    for (int p = 0; p < ret; p++) begin
      e_we = '0; e_wa = '0; e_wd = '0; e_pc = '0;
      if (p < n) begin
        e_we = fl ? 4'h0 : q[p].rf_we;
        e_wa = q[p].dest;
        e_pc = q[p].pc;
        e_wd = (q[p].ex && (q[p].exccode == 5'h04 || q[p].exccode == 5'h05)) ? q[p].badvaddr : q[p].result;
      end
      chk($sformatf("%s.p%0d.rf_we", nm, p), o_we[p], e_we);
      chk($sformatf("%s.p%0d.rf_waddr", nm, p), o_wa[p], e_wa);
      chk($sformatf("%s.p%0d.rf_wdata", nm, p), o_wd[p], e_wd);
      chk($sformatf("%s.p%0d.dbg_pc", nm, p), o_dpc[p], e_pc);
      chk($sformatf("%s.p%0d.dbg_wen", nm, p), o_dwe[p], e_we);
      chk($sformatf("%s.p%0d.dbg_wnum", nm, p), o_dwn[p], e_wa);
      chk($sformatf("%s.p%0d.dbg_wdata", nm, p), o_dwd[p], e_wd);
    end
    chk({nm, ".flush"}, o_fl, fl);
    chk({nm, ".flush_is_eret"}, o_fle, fl && q[0].eret);
    chk({nm, ".flush_pc"}, o_fpc, fl ? q[0].pc : 32'h0);
    chk({nm, ".flush_badvaddr"}, o_fbv, fl ? q[0].badvaddr : 32'h0);
    if (!(fl && q[0].eret)) chk({nm, ".flush_exccode"}, o_fec, fl ? q[0].exccode : 5'h0);
    chk({nm, ".occupancy"}, o_occ, q.size());
    chk({nm, ".in_ready"}, o_rdy, q.size() <= DEPTH - LANES);
    if (k == 1 && track_order && n > 0 && !fl) chk("B.pc_order", o_dpc[0] > last_pc_b, 1'b1);
    n_exp[k] = n;
    fl_exp[k] = fl;
    rdy_exp[k] = (q.size() <= DEPTH - LANES);
  endtask

  task automatic update_models();
    if (fl_exp[0]) begin
      $display("[TB] A flush pc=%h eret=%0d", qa[0].pc, qa[0].eret);
      qa.delete();
    end else begin
      if (n_exp[0] > 0) $display("[TB] A retire %0d from pc=%h", n_exp[0], qa[0].pc);
      for (int i = 0; i < n_exp[0]; i++) qa.delete(0);
      if (rdy_exp[0]) for (int l = 0; l < LANES; l++) if (in_valid[l]) qa.push_back(in_entry[l]);
    end
    if (fl_exp[1]) begin
      qb.delete();
    end else begin
      if (track_order && n_exp[1] > 0) last_pc_b = qb[0].pc;
      for (int i = 0; i < n_exp[1]; i++) qb.delete(0);
      if (rdy_exp[1]) for (int l = 0; l < LANES; l++) if (in_valid[l]) qb.push_back(in_entry[l]);
    end
  endtask

  task automatic cycle();
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    update_models();
    @(negedge clk);
  endtask

  task automatic push_pair();
    in_valid = 2'b11;
    in_entry[0] = mk_ok(pc_ctr, pc_ctr[6:2], pc_ctr ^ 32'h5A5A_0000);
    in_entry[1] = mk_ok(pc_ctr + 32'd4, pc_ctr[7:3], pc_ctr ^ 32'hA5A5_0000);
    pc_ctr = pc_ctr + 32'd8;
  endtask

  int seen7 = 0;
  int kv;

  initial begin
    in_valid = '0;
    in_entry = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    chk("reset.in_ready", rdy_a, 1'b1);
    chk("reset.occupancy", occ_a, 4'd0);
    cycle();

    // Two-lane push, both retire on the next cycle
    in_valid = 2'b11;
    in_entry[0] = mk_ok(32'hBFC0_0000, 5'd1, 32'h11);
    in_entry[1] = mk_ok(32'hBFC0_0004, 5'd2, 32'h22);
    cycle();
    in_valid = '0;
    chk("t1.p0.we", we_a[0], 4'hF);
    chk("t1.p0.waddr", wa_a[0], 5'd1);
    chk("t1.p0.wdata", wd_a[0], 32'h11);
    chk("t1.p1.we", we_a[1], 4'hF);
    chk("t1.p1.waddr", wa_a[1], 5'd2);
    chk("t1.p1.wdata", wd_a[1], 32'h22);
    chk("t1.p0.pc", dpc_a[0], 32'hBFC0_0000);
    cycle();
    chk("t1.occupancy", occ_a, 4'd0);

    // ok r3, AdEL fault, then r5/r6; the fault flushes and squashes a same-cycle push
    in_valid = 2'b11;
    in_entry[0] = mk_ok(32'h0000_0100, 5'd3, 32'h33);
    in_entry[1] = mk_ex(32'h0000_0104, 5'h04, 32'h0000_1003);
    cycle();
    chk("t3.c1.we0", we_a[0], 4'hF);
    chk("t3.c1.waddr0", wa_a[0], 5'd3);
    chk("t3.c1.we1", we_a[1], 4'h0);
    chk("t3.c1.flush", fl_a, 1'b0);
    in_entry[0] = mk_ok(32'h0000_0108, 5'd5, 32'h55);
    in_entry[1] = mk_ok(32'h0000_010C, 5'd6, 32'h66);
    cycle();
    chk("t3.c2.flush", fl_a, 1'b1);
    chk("t3.c2.exccode", fec_a, 5'h04);
    chk("t3.c2.badvaddr", fbv_a, 32'h0000_1003);
    chk("t3.c2.we0", we_a[0], 4'h0);
    chk("t3.c2.dbg_wdata0", dwd_a[0], 32'h0000_1003);
    chk("t3.c2.flush_pc", fpc_a, 32'h0000_0104);
    in_entry[0] = mk_ok(32'h0000_0110, 5'd8, 32'h88);
    in_entry[1] = mk_ok(32'h0000_0114, 5'd9, 32'h99);
    cycle();
    in_valid = '0;
    chk("t3.occupancy", occ_a, 4'd0);
    cycle();

    // ERET at head with an ordinary entry behind it
    in_valid = 2'b11;
    in_entry[0] = mk_eret(32'h0000_01FC);
    in_entry[1] = mk_ok(32'h0000_0200, 5'd9, 32'h99);
    cycle();
    in_valid = '0;
    chk("t4.flush", fl_a, 1'b1);
    chk("t4.is_eret", fle_a, 1'b1);
    chk("t4.flush_pc", fpc_a, 32'h0000_01FC);
    chk("t4.we0", we_a[0], 4'h0);
    chk("t4.we1", we_a[1], 4'h0);
    cycle();
    chk("t4.occupancy", occ_a, 4'd0);

    // Continuous 2-wide pushes; async reset in the middle at B occupancy 5
    track_order = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push_pair();
      cycle();
    end
    chk("rst.B.occ_before", occ_b, 4'd5);
    #2 resetn = 1'b0;
    #1;
    chk("rst.B.we", we_b[0], 4'h0);
    chk("rst.B.wdata", wd_b[0], 32'h0);
    chk("rst.B.pc", dpc_b[0], 32'h0);
    chk("rst.B.occ", occ_b, 4'd0);
    chk("rst.A.we", we_a, 8'h0);
    chk("rst.A.pc", dpc_a, 64'h0);
    chk("rst.A.flush", fl_a, 1'b0);
    qa.delete();
    qb.delete();
    in_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst.B.in_ready_after", rdy_b, 1'b1);
    chk("rst.B.occ_after", occ_b, 4'd0);
    chk("rst.A.occ_after", occ_a, 4'd0);
    for (int c = 0; c < 24; c++) begin
      push_pair();
      cycle();
      if (occ_b == 4'd7) begin
        seen7++;
        chk("fill.B.in_ready_at_7", rdy_b, 1'b0);
      end
    end
    chk("fill.B.reached_7", seen7 > 0, 1'b1);
    in_valid = '0;
    for (int c = 0; c < 20 && qb.size() > 0; c++) cycle();
    chk("fill.B.drained", occ_b, 4'd0);
    track_order = 1'b0;

    // Randomised traffic with faults and ERETs
    for (int c = 0; c < 300; c++) begin
      kv = $urandom_range(0, 2);
      in_valid = 2'((1 << kv) - 1);
      for (int l = 0; l < LANES; l++) begin
        in_entry[l] = rnd_entry(pc_ctr);
        pc_ctr = pc_ctr + 32'd4;
      end
      cycle();
    end
    in_valid = '0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
Parametrised multi-lane successor to the single-entry writeback stage. Accepts up to LANES in-order results per cycle from MEM into a circular commit buffer. Retires up to RETIRE entries per cycle to the regfile write ports and the debug trace. Exceptions and ERET are resolved precisely at the queue head, where they raise the pipeline flush.

Parameters:
LANES, 2, entries MEM can present per cycle (lane 0 oldest)
RETIRE, 2, regfile write ports / max retires per cycle (1..LANES)
DEPTH, 8, buffer entries; power of two, >= 2*LANES

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  LANES  per-lane valid; must be prefix form (1, 11, ...)
in_entry  in  LANES x wb_entry_t  pc, dest, rf_we[3:0], result, ex, exccode, badvaddr, eret
in_ready  out  1  queue can take a full LANES group this cycle
rf_we  out  RETIRE x 4  byte write enables per retire port
rf_waddr  out  RETIRE x 5  destination registers
rf_wdata  out  RETIRE x 32  write data
flush  out  1  one-cycle pulse: exception or ERET retired at head
flush_is_eret  out  1  qualifies flush
flush_pc  out  32  pc of the flushing entry
flush_exccode  out  5  exccode (don't-care when eret)
flush_badvaddr  out  32  badvaddr of the flushing entry
occupancy  out  $clog2(DEPTH)+1  current entry count
debug_wb_pc  out  RETIRE x 32  trace pc per port
debug_wb_rf_wen  out  RETIRE x 4  equals rf_we
debug_wb_rf_wnum  out  RETIRE x 5  equals rf_waddr
debug_wb_rf_wdata  out  RETIRE x 32  equals rf_wdata

Behaviour:
- Storage: DEPTH x wb_entry_t. head/tail pointers $clog2(DEPTH) bits, wrapping modulo DEPTH. count register 0..DEPTH.
- in_ready = (count <= DEPTH-LANES). Registered-state function only; no combinational path from in_valid.
- Push: when in_ready && |in_valid, write popcount(in_valid) lanes at tail, tail+k order. tail += k. Non-prefix in_valid is illegal; the assertion fires in simulation.
- Retire window: head..head+RETIRE-1 limited to count, scanned oldest first. Let j = index of the first entry with ex|eret.
  - No such entry: retire all min(count, RETIRE).
  - j > 0: retire entries 0..j-1 only.
  - j == 0: the head entry retires alone. Its rf_we is forced to 0; flush=1 and flush_* come from the head entry. Next edge: head=tail, count=0, and any same-cycle push is discarded.
- Outputs are combinational from stored entries only (register-derived). Unused ports drive rf_we=0, waddr/wdata/pc=0.
- Latency: an entry pushed at edge t appears on the retire ports in the cycle after t. Minimum MEM-to-regfile latency is 1.
- Throughput: sustained min(LANES, RETIRE) entries per cycle with no stall when RETIRE == LANES.
- Simultaneous push and retire in one cycle: count_next = count + pushed - retired.
- Full (count==DEPTH): in_ready=0 and retire continues. Empty: all outputs idle, flush=0.
- debug_wb_rf_wdata carries badvaddr instead of result when exccode is AdEL/AdES, per the existing trace convention. Those entries still have rf_we forced 0.
- Reset (async, any time including mid-burst): head=tail=count=0. All outputs 0 immediately. Storage contents are not cleared.

Decomposition:
- cpu package: wb_entry_t struct, EXCCODE_* constants, and a wb_retire_t struct {we, waddr, wdata, pc}.
- One sub-module, wb_retire_select: combinational scan of the RETIRE-entry window. It produces the retire count, per-port enables and the flush select. The top keeps storage, pointers and the push logic.

Test Plan:
- Reset, then push lanes {pc 0xBFC00000 r1=0x11, pc 0xBFC00004 r2=0x22}. Next cycle: port0 we=F waddr=1 wdata=0x11, port1 we=F waddr=2 wdata=0x22. occupancy returns to 0.
- RETIRE=1, LANES=2, continuous 2-wide pushes. in_ready drops at count=7 (DEPTH 8). The retire order of pcs is strictly ascending across pointer wrap. No entry is lost or duplicated.
- Group {ok r3, ex exccode=0x04 badvaddr=0x1003, ok r5}. r3 retires in cycle 1. Cycle 2: flush=1, flush_exccode=0x04, flush_badvaddr=0x1003, rf_we=0, debug_wb_rf_wdata=0x1003. The r5 entry and a same-cycle push are dropped, and occupancy=0.
- ERET at head together with an ordinary entry behind it: flush=1, flush_is_eret=1, flush_pc=ERET pc, and nothing is written.
- Assert resetn low mid-burst with count=5: outputs go 0 asynchronously. After release, in_ready=1 and occupancy=0.
